// File: rtl/bcd_display_scheduler.sv
// Time-multiplexed scheduler feeding one shared BCD-to-7-segment decoder.
// It scans DIGITS positions with a blank gap before each digit and applies leading-zero and invalid-code blanking.
module bcd_display_scheduler #(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_GAP = 2
) (
  input  logic                  clk,
  input  logic                  rst_a_p,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  lz_blank,
  output logic [3:0]            bcd_out,
  output logic                  dec_blank,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done,
  output logic                  invalid_bcd
);

  localparam int MAXC = (PRESCALE > BLANK_GAP) ? PRESCALE : BLANK_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t                  state, nxt_state;
  logic [PW-1:0]           ptr, nxt_ptr;
  logic [CW-1:0]           cnt, nxt_cnt;
  logic [DIGITS-1:0][3:0]  pending, active, nxt_active;
  logic [DIGITS-1:0]       bad, nxt_bad, nxt_blank;
  logic                    wrap;

  always_comb begin
    nxt_state  = state;
    nxt_ptr    = ptr;
    nxt_cnt    = cnt;
    nxt_active = active;
    wrap       = 1'b0;
    case (state)
      IDLE: begin
        if (load) nxt_active = bcd_in;
        if (enable) begin
          nxt_state = GAP;
          nxt_ptr   = '0;
          nxt_cnt   = '0;
        end
      end
      GAP: begin
        if (!enable) begin
          nxt_state = IDLE;
          nxt_ptr   = '0;
          nxt_cnt   = '0;
        end else if (cnt == CW'(BLANK_GAP - 1)) begin
          nxt_state = SHOW;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      SHOW: begin
        if (!enable) begin
          nxt_state = IDLE;
          nxt_ptr   = '0;
          nxt_cnt   = '0;
        end else if (cnt == CW'(PRESCALE - 1)) begin
          nxt_state = GAP;
          nxt_cnt   = '0;
          if (ptr == PW'(DIGITS - 1)) begin
            // Frame boundary: the only point where displayed data may change.
            nxt_ptr    = '0;
            wrap       = 1'b1;
            nxt_active = load ? bcd_in : pending;
          end else begin
            nxt_ptr = ptr + PW'(1);
          end
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_ptr   = '0;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Leading zeros: scan from the top nibble down; digit 0 is never suppressed.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    bad      = '0;
    nxt_bad  = '0;
    nxt_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      bad[i]       = (active[i] > 4'd9);
      nxt_bad[i]   = (nxt_active[i] > 4'd9);
      zero_run     = zero_run & (nxt_active[i] == 4'd0);
      nxt_blank[i] = nxt_bad[i] | (lz_blank & (i != 0) & zero_run);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_a_p) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      pending     <= '0;
      active      <= '0;
      bcd_out     <= '0;
      dec_blank   <= 1'b1;
      digit_sel   <= '0;
      frame_done  <= 1'b0;
      invalid_bcd <= 1'b0;
    end else begin
      state       <= nxt_state;
      ptr         <= nxt_ptr;
      cnt         <= nxt_cnt;
      active      <= nxt_active;
      if (load) pending <= bcd_in;
      frame_done  <= wrap;
      invalid_bcd <= |bad;
      case (nxt_state)
        GAP: begin
          bcd_out   <= nxt_active[nxt_ptr];
          dec_blank <= 1'b1;
          digit_sel <= '0;
        end
        SHOW: begin
          bcd_out   <= nxt_active[nxt_ptr];
          dec_blank <= nxt_blank[nxt_ptr];
          digit_sel <= DIGITS'(1) << nxt_ptr;
        end
        default: begin
          bcd_out   <= '0;
          dec_blank <= 1'b1;
          digit_sel <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Scoreboard bench: a frame-time reference model queues expected outputs per edge; a monitor pops and compares.
module tb_bcd_display_scheduler;
  localparam int DIGITS = 4, PRESCALE = 4, BLANK_GAP = 1;
  localparam int PER = PRESCALE + BLANK_GAP;
  localparam int FRAME = DIGITS * PER;

  logic clk = 0;
  logic rst_a_p = 1, enable = 1, load = 1, lz_blank = 0;
  logic [4*DIGITS-1:0] bcd_in = 16'hFFFF;
  logic [3:0] bcd_out;
  logic dec_blank, frame_done, invalid_bcd;
  logic [DIGITS-1:0] digit_sel;

  typedef struct packed {
    logic [3:0] out;
    logic       blank;
    logic [3:0] sel;
    logic       fd;
    logic       inv;
  } exp_t;

  exp_t exp_q[$];
  int n_pass = 0, n_total = 0;

  bcd_display_scheduler #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_GAP(BLANK_GAP)) dut (
    .clk(clk), .rst_a_p(rst_a_p), .enable(enable), .load(load), .bcd_in(bcd_in),
    .lz_blank(lz_blank), .bcd_out(bcd_out), .dec_blank(dec_blank), .digit_sel(digit_sel),
    .frame_done(frame_done), .invalid_bcd(invalid_bcd)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $finish;
  end

  function automatic logic [3:0] nib(input logic [15:0] w, input int d);
    return 4'((w >> (4 * d)) & 16'hF);
  endfunction

  // Reference model: display position is derived from the time elapsed since the frame started.
  initial begin : model
    bit on = 0;
    int t = 0;
    logic [15:0] pend = 0, act = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      e = '0;
      if (rst_a_p) begin
        on = 0; t = 0; pend = 0; act = 0;
        e.blank = 1;
      end else begin
        e.inv = 0;
        for (int d = 0; d < DIGITS; d++) if (nib(act, d) > 9) e.inv = 1;
        if (!on) begin
          if (load) act = bcd_in;
          if (enable) begin on = 1; t = 0; end
        end else if (!enable) begin
          on = 0;
        end else begin
          t++;
          if (t == FRAME) begin
            t = 0; e.fd = 1;
            act = load ? bcd_in : pend;
          end
        end
        if (load) pend = bcd_in;
        if (!on) begin
          e.blank = 1;
        end else begin
          int d, ph;
          d = t / PER; ph = t % PER;
          e.out = nib(act, d);
          if (ph < BLANK_GAP) e.blank = 1;
          else begin
            e.sel = 4'(1 << d);
            e.blank = (nib(act, d) > 9) || (lz_blank && d != 0 && (act >> (4 * d)) == 0);
          end
        end
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    int cyc = 0;
    exp_t e, a;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {bcd_out, dec_blank, digit_sel, frame_done, invalid_bcd};
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL cycle %0d outputs {bcd_out,dec_blank,digit_sel,frame_done,invalid_bcd}: got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                      cyc, a.out, a.blank, a.sel, a.fd, a.inv, e.out, e.blank, e.sel, e.fd, e.inv);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word(input logic [15:0] w);
    load = 1; bcd_in = w; step(1); load = 0;
  endtask

  task automatic restart();
    enable = 0; step(1); enable = 1;
  endtask

  initial begin : driver
    int waited;
    step(2);
    n_total++;
    if ({bcd_out, dec_blank, digit_sel, frame_done, invalid_bcd} === {4'h0, 1'b1, 4'h0, 1'b0, 1'b0}) n_pass++;
    else $display("FAIL reset state: got %h/%b/%b/%b/%b", bcd_out, dec_blank, digit_sel, frame_done, invalid_bcd);
    rst_a_p = 0; load = 0; enable = 0; bcd_in = 0;
    step(1);
    load_word(16'h1234);
    enable = 1;
    waited = 0;
    do begin step(1); waited++; end while (!frame_done && waited < 2 * FRAME);
    n_total++;
    if (frame_done) n_pass++;
    else $display("FAIL frame_done wait expired after %0d cycles", waited);
    if (waited < FRAME + 5) step(FRAME + 5 - waited);
    // mid-frame load while digit 1 shows, then load exactly on a wrap edge
    restart(); step(PER + 3); load_word(16'h9876); step(2 * FRAME);
    restart(); step(FRAME); load_word(16'h4321); step(FRAME);
    enable = 0; lz_blank = 1; step(1);
    load_word(16'h0050); enable = 1; step(FRAME + 2);
    enable = 0; load_word(16'h0000); enable = 1; step(FRAME + 2);
    enable = 0; lz_blank = 0; load_word(16'h12A4); enable = 1; step(FRAME + 2);
    // drop enable in digit 2 SHOW, re-enable, then reset mid-SHOW
    restart(); step(2 * PER + 2); enable = 0; step(1); enable = 1; step(PER + 2);
    rst_a_p = 1; load = 1; bcd_in = 16'h5555; step(1);
    rst_a_p = 0; load = 0; step(3);
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 30) != 0);
      rst_a_p = ($urandom_range(0, 250) == 0);
      load = ($urandom_range(0, 7) == 0);
      bcd_in = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 16'h0FFF) >> (4 * $urandom_range(0, 3)))
                                            : 16'($urandom);
      if ($urandom_range(0, 40) == 0) lz_blank = ~lz_blank;
      step(1);
    end
    rst_a_p = 0; load = 0;
    step(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
